// File: rtl/result_collector.sv
// Result collector: captures scattered multiplier outputs into an m x m register file and
// streams them row-major over valid/ready. Optional macro RESULT_COLLECTOR_DUP_CHECK_EN adds duplicate-write detection.
module result_collector #(
  parameter  int m     = 4,
  localparam int IDX_W = (m > 1) ? $clog2(m) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      z_out,
  input  logic [IDX_W-1:0] z_i,
  input  logic [IDX_W-1:0] z_j,
  input  logic             z_stb,
  input  logic             done,
  output logic [31:0]      out_data,
  output logic [IDX_W-1:0] out_i,
  output logic [IDX_W-1:0] out_j,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             drained,
  output logic             err_missing,
  output logic             err_late,
  output logic             err_dup
);

  localparam int N      = m * m;
  localparam int ADDR_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(m - 1);

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    DRAIN    = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [31:0]       mem [N];
  logic [N-1:0]      fill;
  logic              done_seen;
  logic [IDX_W-1:0]  pi, pj;

  logic              in_range;
  logic              wr_en;
  logic              beat_fire;
  logic              last_ptr;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  // With a power-of-two m every index value is legal, so no range compare is built.
  generate
    if ((1 << IDX_W) == m) begin : g_pow2
      assign in_range = 1'b1;
    end else begin : g_npow2
      assign in_range = (32'(z_i) < m) && (32'(z_j) < m);
    end
  endgenerate

  assign wr_addr   = ADDR_W'(32'(z_i) * m + 32'(z_j));
  assign rd_addr   = ADDR_W'(32'(pi) * m + 32'(pj));
  assign wr_en     = (state == COLLECT) && z_stb && !start && in_range;
  assign beat_fire = (state == DRAIN) && out_ready;
  assign last_ptr  = (pi == LAST_IDX) && (pj == LAST_IDX);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = COLLECT;
    end else begin
      case (state)
        COLLECT:  if ((done_seen || done) && !z_stb) state_nxt = DRAIN;
        DRAIN:    if (beat_fire && last_ptr) state_nxt = COMPLETE;
        COMPLETE: state_nxt = COMPLETE;
        default:  state_nxt = COLLECT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  // NOTE: the register file is deliberately not reset; the fill bitmap alone says what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= z_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill        <= '0;
      done_seen   <= 1'b0;
      pi          <= '0;
      pj          <= '0;
      err_missing <= 1'b0;
      err_late    <= 1'b0;
    end else if (start) begin
      fill        <= '0;
      done_seen   <= 1'b0;
      pi          <= '0;
      pj          <= '0;
      err_missing <= 1'b0;
      err_late    <= 1'b0;
    end else begin
      if (wr_en) fill[wr_addr] <= 1'b1;
      if (state == COLLECT && done) done_seen <= 1'b1;
      // Entry to DRAIN consumes done_seen; a hole in the bitmap at that moment is sticky.
      if (state == COLLECT && state_nxt == DRAIN) begin
        done_seen <= 1'b0;
        if (!(&fill)) err_missing <= 1'b1;
      end
      if (z_stb && (state != COLLECT || !in_range)) err_late <= 1'b1;
      if (beat_fire) begin
        if (pj == LAST_IDX) begin
          pj <= '0;
          pi <= (pi == LAST_IDX) ? '0 : pi + 1'b1;
        end else begin
          pj <= pj + 1'b1;
        end
      end
    end
  end

`ifdef RESULT_COLLECTOR_DUP_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        err_dup <= 1'b0;
    else if (start)                 err_dup <= 1'b0;
    else if (wr_en && fill[wr_addr]) err_dup <= 1'b1;
  end
`else
  assign err_dup = 1'b0;
`endif

  // Stream outputs are pure functions of the held pointer, so they stay stable while stalled.
  assign out_valid = (state == DRAIN);
  assign out_last  = out_valid && last_ptr;
  assign out_data  = (out_valid && fill[rd_addr]) ? mem[rd_addr] : 32'h0;
  assign out_i     = out_valid ? pi : '0;
  assign out_j     = out_valid ? pj : '0;
  assign drained   = (state == COMPLETE);

endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector (m = 4): builds expected row-major beats from a
// reference copy of the written matrix and compares them against the stream.
module tb_result_collector;

  localparam int M  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst, start, z_stb, done, out_ready;
  logic [31:0]   z_out;
  logic [IW-1:0] z_i, z_j;
  logic [31:0]   out_data;
  logic [IW-1:0] out_i, out_j;
  logic          out_valid, out_last, drained;
  logic          err_missing, err_late, err_dup;

  typedef struct {
    int          i;
    int          j;
    logic [31:0] data;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] mdl_mem [M*M];
  bit          mdl_fill [M*M];
  bit          mdl_dup;
  int          checks = 0;
  int          errors = 0;

  result_collector #(.m(M)) dut (
    .clk(clk), .rst(rst), .start(start),
    .z_out(z_out), .z_i(z_i), .z_j(z_j), .z_stb(z_stb), .done(done),
    .out_data(out_data), .out_i(out_i), .out_j(out_j),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .drained(drained), .err_missing(err_missing), .err_late(err_late), .err_dup(err_dup)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic write_elem(input int i, input int j, input logic [31:0] d, input bit with_done);
    z_stb = 1'b1;
    z_i   = IW'(i);
    z_j   = IW'(j);
    z_out = d;
    done  = with_done;
    if (mdl_fill[i*M+j]) mdl_dup = 1'b1;
    mdl_fill[i*M+j] = 1'b1;
    mdl_mem[i*M+j]  = d;
    @(negedge clk);
    z_stb = 1'b0;
    done  = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < M*M; k++) mdl_fill[k] = 1'b0;
    mdl_dup = 1'b0;
  endtask

  // Writes every element in reverse order, optionally skipping one position.
  task automatic fill_all(input logic [31:0] base, input int skip_i, input int skip_j);
    for (int i = M-1; i >= 0; i--)
      for (int j = M-1; j >= 0; j--)
        if (!(i == skip_i && j == skip_j)) write_elem(i, j, base + 32'(16*i + j), 1'b0);
  endtask

  task automatic push_expected();
    beat_t b;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        b.i = i;
        b.j = j;
        b.data = mdl_fill[i*M+j] ? mdl_mem[i*M+j] : 32'h0;
        exp_q.push_back(b);
      end
  endtask

  function automatic bit mdl_missing();
    bit miss = 1'b0;
    for (int k = 0; k < M*M; k++) if (!mdl_fill[k]) miss = 1'b1;
    return miss;
  endfunction

  task automatic pulse_done();
    push_expected();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    #1;
    check("valid_after_done", out_valid, 1);
    check("err_missing_on_entry", err_missing, mdl_missing());
  endtask

  // pat 0: ready always high; pat 1: ready cycles 1,0,0,1.
  task automatic stream(input int pat, input int late_at, input int abort_at);
    int cycles   = 0;
    int accepted = 0;
    bit injected = 1'b0;
    bit rdy;
    beat_t e;
    while (exp_q.size() > 0) begin
      if (cycles >= 400) begin
        check("drain_timeout_left", exp_q.size(), 0);
        exp_q.delete();
        break;
      end
      if (abort_at >= 0 && accepted == abort_at) begin
        check("err_late_before_abort", err_late, (late_at >= 0) ? 1 : 0);
        out_ready = 1'b0;
        do_start();
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_last", out_last, 0);
        check("abort_drained", drained, 0);
        check("abort_err_late", err_late, 0);
        check("abort_err_missing", err_missing, 0);
        check("abort_err_dup", err_dup, 0);
        exp_q.delete();
        return;
      end
      rdy = (pat == 0) ? 1'b1 : ((cycles % 4) == 0 || (cycles % 4) == 3);
      out_ready = rdy;
      if (late_at >= 0 && accepted == late_at && !injected) begin
        z_stb = 1'b1; z_i = IW'(M-1); z_j = IW'(M-1); z_out = 32'hDEADBEEF;
        injected = 1'b1;
      end else begin
        z_stb = 1'b0;
      end
      #1;
      e = exp_q[0];
      check("beat_valid", out_valid, 1);
      check("beat_i", out_i, e.i);
      check("beat_j", out_j, e.j);
      check("beat_data", out_data, e.data);
      check("beat_last", out_last, (exp_q.size() == 1) ? 1 : 0);
      if (rdy) begin
        void'(exp_q.pop_front());
        accepted++;
      end
      cycles++;
      @(negedge clk);
    end
    z_stb = 1'b0;
    out_ready = 1'b0;
    #1;
    check("accepted_count", accepted, M*M);
    check("end_valid", out_valid, 0);
    check("end_last", out_last, 0);
    check("end_drained", drained, 1);
    if (late_at >= 0) check("err_late_sticky", err_late, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; z_stb = 1'b0; done = 1'b0; out_ready = 1'b0;
    z_out = '0; z_i = '0; z_j = '0;
    mdl_dup = 1'b0;
    for (int k = 0; k < M*M; k++) begin mdl_fill[k] = 1'b0; mdl_mem[k] = '0; end
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_drained", drained, 0);
    check("rst_data", out_data, 0);
    check("rst_errs", {err_missing, err_late, err_dup, out_last}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Full matrix, reverse-order writes, ready held high.
    fill_all(32'h3F800000, -1, -1);
    pulse_done();
    stream(0, -1, -1);
    check("t1_errs", {err_missing, err_late, err_dup}, 0);

    // Full matrix with backpressure pattern 1,0,0,1.
    do_start();
    #1 check("start_clears_drained", drained, 0);
    fill_all(32'h40000100, -1, -1);
    pulse_done();
    stream(1, -1, -1);

    // Element [2][3] omitted: reported missing and streamed as zero.
    do_start();
    fill_all(32'h41000000, 2, 3);
    pulse_done();
    stream(0, -1, -1);
    check("t3_err_missing", err_missing, 1);

    // Final element coincident with done: drain starts one cycle later.
    do_start();
    fill_all(32'h42000000, 3, 3);
    write_elem(3, 3, 32'hC0FFEE33, 1'b1);
    push_expected();
    #1 check("coincident_wait", out_valid, 0);
    @(negedge clk);
    #1;
    check("coincident_valid", out_valid, 1);
    check("coincident_missing", err_missing, 0);
    stream(0, -1, -1);

    // Late strobe during drain, then abort the stream with start.
    do_start();
    fill_all(32'h43000000, -1, -1);
    pulse_done();
    stream(1, 3, 8);
    fill_all(32'h44000000, -1, -1);
    pulse_done();
    stream(0, -1, -1);

    // Duplicate write to [1][1]: last value wins.
    do_start();
    fill_all(32'h45000000, -1, -1);
    write_elem(1, 1, 32'hBBBB0011, 1'b0);
    #1;
`ifdef RESULT_COLLECTOR_DUP_CHECK_EN
    check("dup_flag", err_dup, 1);
`else
    check("dup_flag", err_dup, 0);
`endif
    pulse_done();
    stream(0, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Sits directly downstream of the row/column multiplier stage.
- Captures each scattered result element (z_out tagged with z_i/z_j, qualified by z_stb) into an m x m register file and tracks which elements have arrived.
- After the multiplier's done, streams the complete result matrix out in row-major order over a valid/ready interface.
- Elements are 32-bit IEEE-754 single words, stored and forwarded bit-exact with no arithmetic.

Parameters:
m, 4, result matrix dimension (m x m elements); legal range 2..16
IDX_W, $clog2(m), index width (derived; not overridden)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse: clear fill bitmap, re-enter COLLECT
z_out  input  32  result element from multiplier
z_i  input  IDX_W  row index of z_out
z_j  input  IDX_W  column index of z_out
z_stb  input  1  z_out/z_i/z_j valid this cycle
done  input  1  multiplier finished (level or pulse; sampled each cycle)
out_data  output  32  streamed element
out_i  output  IDX_W  row of out_data
out_j  output  IDX_W  column of out_data
out_valid  output  1  out_* valid
out_ready  input  1  consumer accepts
out_last  output  1  high with final beat (i=j=m-1)
drained  output  1  level, full matrix delivered
err_missing  output  1  sticky: drain began with unfilled elements
err_late  output  1  sticky: z_stb seen outside COLLECT
err_dup  output  1  sticky: element written twice (feature-dependent)

Behaviour:
- Clock/reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset:
  - state = COLLECT; fill bitmap, drain pointer and all outputs = 0; done_seen = 0.
  - Register-file contents are not reset.
- State COLLECT:
  - On z_stb: mem[z_i][z_j] <= z_out and fill[z_i][z_j] <= 1. A rewrite overwrites; the last write wins.
  - Indices >= m (non-power-of-2 m): write dropped, err_late set.
  - done high sets done_seen.
- COLLECT -> DRAIN:
  - Transition on the edge after done_seen is set and no z_stb is present that cycle.
  - z_stb coincident with done: the write is captured first, and the transition occurs one cycle later.
  - Any fill bit 0 on entry to DRAIN: err_missing set.
- State DRAIN:
  - Pointer (pi, pj) starts at (0, 0). out_valid = 1 from the first DRAIN cycle, which is one cycle after done is sampled when z_stb is idle.
  - out_data = mem[pi][pj] if fill[pi][pj], else 32'h0. out_i = pi, out_j = pj.
  - out_data, out_i and out_j are held stable while out_valid && !out_ready.
  - On out_valid && out_ready: advance pj; on pj wrap to 0, advance pi.
  - out_last = out_valid && pi == m-1 && pj == m-1.
  - Accepting the last beat -> COMPLETE.
- State COMPLETE:
  - out_valid = 0; drained = 1 until start or rst.
- start:
  - Accepted in any state; highest priority after rst.
  - Clears fill, done_seen, pointer, drained and all err_* flags; state -> COLLECT next cycle.
  - start mid-DRAIN aborts the stream immediately, with no out_last.
  - z_stb in the same cycle as start is discarded.
- z_stb while in DRAIN or COMPLETE: ignored, err_late set.
- done while in DRAIN or COMPLETE: ignored.
- Throughput: one beat per cycle with out_ready held high; m*m beats total.

Optional Feature:
- Macro: RESULT_COLLECTOR_DUP_CHECK_EN.
- Defined: a z_stb in COLLECT to an element whose fill bit is already 1 sets err_dup (sticky). The data is still overwritten.
- Undefined: err_dup is tied 0 and no duplicate-detection logic is built. The port remains present in both builds.

Test Plan:
- Reset, m=4; write 16 elements in reverse order with z_out = 32'h3F800000 + 16*i + j, then pulse done → out_valid one cycle after done; 16 row-major beats with matching data; out_last on beat 16 only; drained = 1; all err_* = 0.
- Full drain with out_ready toggled 1,0,0,1 → each beat held stable while stalled; no beat lost or duplicated; exactly 16 accepted.
- Write only 15 elements (omit [2][3]), then done → err_missing = 1; beat (2,3) outputs 32'h0.
- z_stb and done in the same cycle on the final element → element captured; DRAIN entered one cycle later; correct data.
- z_stb during DRAIN → err_late = 1 and stream data unchanged. Then start mid-DRAIN → out_valid drops next cycle, all flags clear, state returns to COLLECT.
- DUP_CHECK_EN defined: write [1][1] twice (values A then B) → err_dup = 1 and beat (1,1) = B. Undefined: same stimulus → err_dup = 0.
